req_split_stream: RTL

REQ_SPLIT_STREAM -- requirements
Module: req_split_stream

---
 rtl/req_split_pkg.sv | 30 +++
 rtl/req_split_oreg.sv | 36 +++
 rtl/req_split_stream.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/req_split_pkg.sv
// Shared types and widths for the request splitter: the request layout
// carried on both the sink and source streams, and the splitter FSM states.
package req_split_pkg;

  localparam int ADDR_BITS   = 48;
  localparam int LEN_BITS    = 28;
  localparam int DEST_BITS   = 4;
  // Default split boundary exponent: chunks never cross a 4 KiB page.
  localparam int PG_BITS_DEF = 12;

  // Request / chunk layout, MSB first: {vaddr, len, ctl, dest}.
  typedef struct packed {
    logic [ADDR_BITS-1:0] vaddr;
    logic [LEN_BITS-1:0]  len;
    logic                 ctl;
    logic [DEST_BITS-1:0] dest;
  } req_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_e;

  // Smaller of two lengths; used to clip a chunk at the page boundary.
  function automatic logic [LEN_BITS-1:0] min_len(input logic [LEN_BITS-1:0] a,
                                                  input logic [LEN_BITS-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/req_split_oreg.sv
// One-entry val/rdy register slice. Holds a chunk until the downstream
// consumer takes it; loads a new one whenever it is empty or being drained
// in the same cycle, so it sustains one transfer per cycle.
module req_split_oreg
  import req_split_pkg::*;
#(
  parameter type T = req_t
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic in_val,
  output logic in_rdy,
  input  T     in_data,
  output logic out_val,
  input  logic out_rdy,
  output T     out_data
);

  // Free this cycle if empty or the held entry leaves at this edge; the held
  // entry therefore cannot change while out_val is high and out_rdy is low.
  assign in_rdy = !out_val || out_rdy;

  // Slot register: val/data update only when the slot is free.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_val  <= 1'b0;
      out_data <= '0;
    end else if (in_rdy) begin
      out_val <= in_val;
      if (in_val) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/req_split_stream.sv
// Splits each incoming request into chunks that never cross a 2^PG_BITS byte
// boundary. The first chunk is computed straight from the sink data so it
// is registered at the accepting edge; later chunks come from the latched
// request state. Chunks leave through a one-entry register slice.
//
// Handshake (both ports): a beat transfers on a rising aclk edge where val
// and rdy are both high. A source holding val high keeps its data stable
// until the transfer; rdy may be computed from val.
module req_split_stream
  import req_split_pkg::*;
#(
  parameter int  PG_BITS = req_split_pkg::PG_BITS_DEF,
  parameter type QTYPE   = req_t
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic val_snk,
  output logic rdy_snk,
  input  QTYPE data_snk,
  output logic val_src,
  input  logic rdy_src,
  output QTYPE data_src,
  output logic dbg_state
);

  // A chunk length must be able to hold a full page.
  if (LEN_BITS < PG_BITS + 1) begin : g_len_too_narrow
    $error("req_split_stream: LEN_BITS must be at least PG_BITS+1");
  end

  localparam logic [LEN_BITS-1:0] PAGE_BYTES = LEN_BITS'(1) << PG_BITS;

  split_state_e          state_q, state_d;
  logic [ADDR_BITS-1:0]  vaddr_q, vaddr_d;
  logic [LEN_BITS-1:0]   rem_q,   rem_d;
  logic                  ctl_q,   ctl_d;
  logic [DEST_BITS-1:0]  dest_q,  dest_d;
  // Low during reset and until the first edge after release, so rdy_snk
  // cannot rise combinationally on the reset deassertion itself.
  logic                  run_q;

  req_t                  snk_req;
  logic [ADDR_BITS-1:0]  src_vaddr;
  logic [LEN_BITS-1:0]   src_rem;
  logic                  src_ctl;
  logic [DEST_BITS-1:0]  src_dest;
  logic [LEN_BITS-1:0]   page_room;
  logic [LEN_BITS-1:0]   chunk_len;
  logic                  is_final;
  logic                  ld_val;
  logic                  oreg_rdy;
  req_t                  chunk;
  req_t                  oreg_data;

  assign snk_req   = req_t'(data_snk);
  assign dbg_state = state_q;

  // State and request registers; everything clears on reset, which drops
  // any request still being split.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      vaddr_q <= '0;
      rem_q   <= '0;
      ctl_q   <= 1'b0;
      dest_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      rem_q   <= rem_d;
      ctl_q   <= ctl_d;
      dest_q  <= dest_d;
      run_q   <= 1'b1;
    end
  end

  // Next-state, chunk formation and sink ready. In ST_IDLE the chunk is
  // built from the sink request; in ST_SPLIT from the latched remainder.
  always_comb begin
    state_d   = state_q;
    vaddr_d   = vaddr_q;
    rem_d     = rem_q;
    ctl_d     = ctl_q;
    dest_d    = dest_q;
    src_vaddr = vaddr_q;
    src_rem   = rem_q;
    src_ctl   = ctl_q;
    src_dest  = dest_q;
    ld_val    = 1'b0;
    rdy_snk   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rdy_snk   = run_q && oreg_rdy;
        src_vaddr = snk_req.vaddr;
        src_rem   = snk_req.len;
        src_ctl   = snk_req.ctl;
        src_dest  = snk_req.dest;
        ld_val    = val_snk && run_q && oreg_rdy;
      end
      ST_SPLIT: begin
        ld_val = oreg_rdy;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bytes left before the next page boundary (1..2^PG_BITS).
    page_room = PAGE_BYTES - LEN_BITS'(src_vaddr[PG_BITS-1:0]);
    chunk_len = min_len(src_rem, page_room);
    // A zero-length request takes this path too: one chunk of length 0.
    is_final  = (src_rem == chunk_len);

    chunk.vaddr = src_vaddr;
    chunk.len   = chunk_len;
    chunk.ctl   = is_final ? src_ctl : 1'b0;
    chunk.dest  = src_dest;

    if (ld_val) begin
      // Address wraps silently at 2^ADDR_BITS.
      vaddr_d = src_vaddr + ADDR_BITS'(chunk_len);
      rem_d   = src_rem - chunk_len;
      ctl_d   = src_ctl;
      dest_d  = src_dest;
      state_d = is_final ? ST_IDLE : ST_SPLIT;
    end
  end

  req_split_oreg #(
    .T (req_t)
  ) u_oreg (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .in_val   (ld_val),
    .in_rdy   (oreg_rdy),
    .in_data  (chunk),
    .out_val  (val_src),
    .out_rdy  (rdy_src),
    .out_data (oreg_data)
  );

  assign data_src = QTYPE'(oreg_data);

endmodule
